// File: rtl/imm_pack.sv
// imm_pack: encodes an immediate into a RISC-V style instruction template and
// checks that the value survives the encoding.
//
// A request is taken in IDLE, packed in PACK, range/alignment-checked in CHECK
// and presented in HOLD until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   in_valid   request present            in_ready   request accepted (IDLE only)
//   instr_in   template instruction       immsrc     format (0 I,1 S,2 B,3 J,4 U)
//   imm        immediate to encode
//   out_valid  result present (HOLD)      out_ready  consumer takes result
//   instr_out  encoded instruction
//   err_range  immediate not representable in the format
//   err_align  B/J immediate with bit 0 set
//   err_src    immsrc not a valid format
//   err_count  saturating count of completed results with any error
module imm_pack #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr_in,
  input  logic [2:0]       immsrc,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr_out,
  output logic             err_range,
  output logic             err_align,
  output logic             err_src,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, PACK, CHECK, HOLD} state_t;

  state_t state, state_nxt;

  logic [31:0]        instr_p0;
  logic [31:0]        imm_p0;
  logic [2:0]         src_p0;
  logic [31:0]        packed_w;
  logic [31:0]        packed_p1;
  logic signed [31:0] recon_w;
  logic signed [31:0] imm_cmp_w;
  logic               range_w;
  logic               align_w;
  logic               src_w;
  logic               accept;
  logic               done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign in_ready  = reset_n && (state == IDLE);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign done      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PACK;
      PACK:    state_nxt = CHECK;
      CHECK:   state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: capture request ----
  always_ff @(posedge clk) begin
    if (accept) begin
      instr_p0 <= instr_in;
      imm_p0   <= imm;
      src_p0   <= immsrc;
    end
  end

  // Fields not owned by the immediate keep the template bits.
  always_comb begin
    packed_w = instr_p0;
    case (src_p0)
      3'd0: packed_w[31:20] = imm_p0[11:0];
      3'd1: begin
        packed_w[31:25] = imm_p0[11:5];
        packed_w[11:7]  = imm_p0[4:0];
      end
      3'd2: begin
        packed_w[31]    = imm_p0[12];
        packed_w[30:25] = imm_p0[10:5];
        packed_w[11:8]  = imm_p0[4:1];
        packed_w[7]     = imm_p0[11];
      end
      3'd3: begin
        packed_w[31]    = imm_p0[20];
        packed_w[30:21] = imm_p0[10:1];
        packed_w[20]    = imm_p0[11];
        packed_w[19:12] = imm_p0[19:12];
      end
      3'd4: packed_w[31:12] = imm_p0[31:12];
      default: ;
    endcase
  end

  // ---- stage p1: packed word ----
  always_ff @(posedge clk) begin
    if (state == PACK) packed_p1 <= packed_w;
  end

  // Decode the packed word back to a 32-bit immediate; any difference from
  // the requested value means bits were lost in the encoding.
  always_comb begin
    recon_w   = '0;
    imm_cmp_w = $signed(imm_p0);
    case (src_p0)
      3'd0: recon_w = $signed({{20{packed_p1[31]}}, packed_p1[31:20]});
      3'd1: recon_w = $signed({{20{packed_p1[31]}}, packed_p1[31:25], packed_p1[11:7]});
      3'd2: begin
        recon_w      = $signed({{19{packed_p1[31]}}, packed_p1[31], packed_p1[7],
                                 packed_p1[30:25], packed_p1[11:8], 1'b0});
        imm_cmp_w[0] = 1'b0;
      end
      3'd3: begin
        recon_w      = $signed({{11{packed_p1[31]}}, packed_p1[31], packed_p1[19:12],
                                 packed_p1[20], packed_p1[30:21], 1'b0});
        imm_cmp_w[0] = 1'b0;
      end
      3'd4: recon_w = $signed({packed_p1[31:12], 12'h000});
      default: ;
    endcase
    src_w   = (src_p0 > 3'd4);
    range_w = !src_w && (recon_w != imm_cmp_w);
    align_w = ((src_p0 == 3'd2) || (src_p0 == 3'd3)) && imm_p0[0];
  end

  // ---- stage p2: result registers, held through HOLD ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instr_out <= '0;
      err_range <= 1'b0;
      err_align <= 1'b0;
      err_src   <= 1'b0;
    end else if (state == CHECK) begin
      instr_out <= packed_p1;
      err_range <= range_w;
      err_align <= align_w;
      err_src   <= src_w;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) err_count <= '0;
    else if (done && (err_range || err_align || err_src)) err_count <= sat_inc(err_count);
  end

endmodule

// File: tb/tb_imm_pack.sv
module tb_imm_pack;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] instr_in = '0, imm = '0;
  logic [2:0]  immsrc = '0;
  logic        in_ready, out_valid, err_range, err_align, err_src;
  logic [31:0] instr_out;
  logic [7:0]  err_count;

  logic        b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic [31:0] b_instr_in = 32'h0000_0013, b_imm = '0;
  logic [2:0]  b_immsrc = 3'b101;
  logic        b_in_ready, b_out_valid, b_err_range, b_err_align, b_err_src;
  logic [31:0] b_instr_out;
  logic [1:0]  b_err_count;

  always #5 clk = ~clk;

  imm_pack #(.CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .immsrc(immsrc), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .instr_out(instr_out), .err_range(err_range),
    .err_align(err_align), .err_src(err_src), .err_count(err_count));

  imm_pack #(.CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .instr_in(b_instr_in), .immsrc(b_immsrc), .imm(b_imm), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .instr_out(b_instr_out), .err_range(b_err_range),
    .err_align(b_err_align), .err_src(b_err_src), .err_count(b_err_count));

  typedef struct packed {
    logic [31:0] instr;
    logic        rng;
    logic        aln;
    logic        src;
  } exp_t;

  exp_t q[$];
  int   cnt_exp = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s timed out", name);
  endtask

  // Model: where each immediate bit lands in the instruction.
  function automatic logic [31:0] model_instr(input logic [31:0] ins, input logic [2:0] s,
                                              input logic [31:0] im);
    case (s)
      3'd0: return {im[11:0], ins[19:0]};
      3'd1: return {im[11:5], ins[24:12], im[4:0], ins[6:0]};
      3'd2: return {im[12], im[10:5], ins[24:12], im[4:1], im[11], ins[6:0]};
      3'd3: return {im[20], im[10:1], im[11], im[19:12], ins[11:0]};
      3'd4: return {im[31:12], ins[11:0]};
      default: return ins;
    endcase
  endfunction

  // Model: representable signed ranges of each format.
  function automatic logic model_range(input logic [2:0] s, input logic [31:0] im);
    longint v;
    v = longint'($signed(im));
    if (s == 3'd2 || s == 3'd3) v = v - longint'(im[0]);
    case (s)
      3'd0, 3'd1: return (v < -2048) || (v > 2047);
      3'd2:       return (v < -4096) || (v > 4095);
      3'd3:       return (v < -(64'sd1 << 20)) || (v > (64'sd1 << 20) - 1);
      3'd4:       return im[11:0] != 12'h000;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [2:0] s, input logic [31:0] im);
    exp_t e;
    e.instr = model_instr(ins, s, im);
    e.rng   = model_range(s, im);
    e.aln   = (s == 3'd2 || s == 3'd3) ? im[0] : 1'b0;
    e.src   = (s > 3'd4);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      cnt_exp = 0;
    end else begin
      check("err_count", {24'h0, err_count}, cnt_exp);
      if (out_valid) begin
        check("in_ready_in_hold", {31'h0, in_ready}, 32'h0);
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out_valid actual=1 required=0");
        end else begin
          check("instr_out", instr_out, q[0].instr);
          check("err_range", {31'h0, err_range}, {31'h0, q[0].rng});
          check("err_align", {31'h0, err_align}, {31'h0, q[0].aln});
          check("err_src",   {31'h0, err_src},   {31'h0, q[0].src});
          if (out_ready) begin
            if ((q[0].rng || q[0].aln || q[0].src) && cnt_exp < 255) cnt_exp++;
            void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [2:0] s, input logic [31:0] im,
                      input int hold, input bit early);
    int n;
    bit got;
    @(posedge clk); #1;
    instr_in = ins; immsrc = s; imm = im; in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1;
    end
    if (!got) begin
      fail_now("accept");
      in_valid = 1'b0;
      return;
    end
    q.push_back(model(ins, s, im));
    @(posedge clk); #1;
    in_valid = 1'b0;
    instr_in = $urandom; immsrc = 3'($urandom); imm = $urandom;
    if (early) out_ready = 1'b1;
    n = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) got = 1;
    end
    if (!got) begin
      fail_now("out_valid");
      out_ready = 1'b0;
      return;
    end
    check("latency", n, 3);
    if (!early) begin
      repeat (hold) @(negedge clk);
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    bit got;
    logic [2:0] s;
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_in_ready",  {31'h0, in_ready}, 32'h0);
    check("rst_instr_out", instr_out, 32'h0);
    check("rst_errs", {29'h0, err_range, err_align, err_src}, 32'h0);
    check("rst_err_count", {24'h0, err_count}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", {31'h0, in_ready}, 32'h1);

    send(32'h0000_0093, 3'b000, 32'hFFFF_FFFF, 0, 0);
    check("lit_i_instr", instr_out, 32'hFFF0_0093);
    check("lit_i_errs", {29'h0, err_range, err_align, err_src}, 32'h0);

    send(32'h0000_0063, 3'b010, 32'hFFFF_FFF8, 1, 0);
    check("lit_b_instr", instr_out, 32'hFE00_0CE3);
    check("lit_b_errs", {29'h0, err_range, err_align, err_src}, 32'h0);

    send(32'h0000_0013, 3'b000, 32'h0000_0800, 0, 0);
    check("lit_i_range", {31'h0, err_range}, 32'h1);
    check("lit_count_1", {24'h0, err_count}, 32'h1);

    send(32'h0000_0037, 3'b100, 32'h1234_5001, 0, 1);
    check("lit_u_range", {31'h0, err_range}, 32'h1);
    check("lit_u_instr", instr_out, 32'h1234_5037);

    send(32'h0000_006F, 3'b011, 32'h0000_0005, 0, 0);
    check("lit_j_align", {31'h0, err_align}, 32'h1);
    check("lit_j_range", {31'h0, err_range}, 32'h0);

    send(32'hDEAD_BEEF, 3'b110, 32'h0000_1234, 5, 0);
    check("lit_src_err", {31'h0, err_src}, 32'h1);
    check("lit_src_pass", instr_out, 32'hDEAD_BEEF);
    check("lit_count_4", {24'h0, err_count}, 32'h4);

    send(32'h0000_0023, 3'b001, 32'hFFFF_F805, 0, 0);
    send(32'h0000_0023, 3'b001, 32'h0000_07FF, 2, 0);
    send(32'h0000_0037, 3'b100, 32'hABCD_E000, 0, 0);
    send(32'h0000_006F, 3'b011, 32'hFFF0_0000, 0, 0);
    send(32'h0000_006F, 3'b011, 32'h0010_0000, 0, 0);
    send(32'h0000_0063, 3'b010, 32'h0000_1000, 0, 0);
    send(32'h0000_0063, 3'b010, 32'hFFFF_F000, 0, 0);
    for (int i = 0; i < 8; i++) begin
      s = 3'(i % 6);
      send($urandom, s, (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 4095)) - 32'd2048, i % 3, 0);
    end

    // reset while the request sits in CHECK
    @(posedge clk); #1;
    instr_in = 32'h0000_0093; immsrc = 3'b000; imm = 32'h0000_0800; in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1;
    end
    if (!got) fail_now("accept_rst");
    q.push_back(model(32'h0000_0093, 3'b000, 32'h0000_0800));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rstchk_in_ready", {31'h0, in_ready}, 32'h1);
    check("rstchk_out_valid", {31'h0, out_valid}, 32'h0);
    check("rstchk_count", {24'h0, err_count}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rstchk_no_result", {31'h0, out_valid}, 32'h0);
    end

    // 2-bit counter saturation
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      b_in_valid = 1'b1;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (b_in_ready) got = 1;
      end
      if (!got) fail_now("b_accept");
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (b_out_valid) got = 1;
      end
      if (!got) fail_now("b_out_valid");
      else check("b_err_src", {31'h0, b_err_src}, 32'h1);
      @(negedge clk);
      check("b_err_count", {30'h0, b_err_count}, (i + 1 > 3) ? 32'd3 : 32'(i + 1));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
